// File: rtl/pattern_serializer_if.sv
// Bus between a frame source and pattern_serializer_1101.
//   load        : start-of-frame request (source -> serializer)
//   data_in     : WIDTH-bit frame word (source -> serializer)
//   out         : serial bit line, MSB first (serializer -> source/detector)
//   out_valid   : out carries a frame bit
//   busy        : serializer is in SHIFT or DONE
//   done        : one-cycle pulse after the last bit
//   match       : reference-matcher pulse, cycle after a bit completes the pattern
//   match_count : matches in the current or last frame
interface pattern_serializer_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned MCW = $clog2(WIDTH + 1);

    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic             match;
    logic [MCW-1:0]   match_count;

    modport master (
        output load, data_in,
        input  out, out_valid, busy, done, match, match_count
    );

    modport slave (
        input  load, data_in,
        output out, out_valid, busy, done, match, match_count
    );
endinterface

// File: rtl/pattern_serializer_1101.sv
// Parallel-to-serial transmitter with an overlapping Moore reference matcher.
// Loads a WIDTH-bit word on an accepted load and sends it MSB first, one bit
// per clk. In parallel it compares the last PAT_LEN sent bits of the current
// frame with PATTERN and reports a registered match pulse and a per-frame count.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : pattern_serializer_if slave (load/data_in in; out, out_valid,
//         busy, done, match, match_count out; all outputs registered)
module pattern_serializer_1101 #(
    parameter int unsigned         WIDTH   = 16,
    parameter int unsigned         PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1101
) (
    input  logic                 clk,
    input  logic                 rst,
    pattern_serializer_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(WIDTH);
    localparam int unsigned MCW    = $clog2(WIDTH + 1);
    localparam int unsigned HIST_W = PAT_LEN - 1;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FIRST_CMP = CNT_W'(PAT_LEN - 1);
    localparam logic [MCW-1:0]   MC_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state;
    logic [WIDTH-2:0]    sreg;    // bits still to send after the one on out
    logic [HIST_W-1:0]   hist;    // previously sent bits of this frame
    logic [CNT_W-1:0]    cnt;     // index of the bit currently on out
    logic [PAT_LEN-1:0]  window;
    logic                hit;

    // Window ends with the bit on out; only full windows inside the frame count.
    assign window = {hist, bus.out};
    assign hit    = (window == PATTERN) && (cnt >= FIRST_CMP);

    // Frame sequencer, shift path and reference matcher.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            sreg            <= '0;
            hist            <= '0;
            cnt             <= '0;
            bus.out         <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.match       <= 1'b0;
            bus.match_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done  <= 1'b0;
                    bus.match <= 1'b0;
                    if (bus.load) begin
                        state           <= SHIFT;
                        bus.out         <= bus.data_in[WIDTH-1];
                        sreg            <= bus.data_in[WIDTH-2:0];
                        bus.out_valid   <= 1'b1;
                        bus.busy        <= 1'b1;
                        cnt             <= '0;
                        hist            <= '0;
                        bus.match_count <= '0;
                    end
                end
                SHIFT: begin
                    hist      <= window[HIST_W-1:0];
                    bus.match <= hit;
                    if (hit && (bus.match_count != MC_MAX)) begin
                        bus.match_count <= bus.match_count + MCW'(1);
                    end
                    if (cnt == LAST_BIT) begin
                        state         <= DONE;
                        bus.out       <= 1'b0;
                        bus.out_valid <= 1'b0;
                        bus.done      <= 1'b1;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        bus.out <= sreg[WIDTH-2];
                        sreg    <= {sreg[WIDTH-3:0], 1'b0};
                    end
                end
                DONE: begin
                    // load is not sampled here, so it cannot queue a frame
                    state     <= IDLE;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b0;
                    bus.match <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/pattern_serializer_1101.md
Name: pattern_serializer_1101

Overview:
- Parallel-to-serial bit-stream transmitter; the driving end of the serial 1101 sequence-detector interface.
- Loads a WIDTH-bit word and shifts it out MSB-first, one bit per clk, on a single-bit line.
- In parallel it runs a Moore-style overlapping reference matcher for PATTERN over the transmitted bits, giving an expected-match pulse and a per-frame count.
- Benches cross-check detector output against this matcher.

Parameters:
- WIDTH, 16, number of bits per frame (>= PAT_LEN).
- PAT_LEN, 4, length of the reference pattern.
- PATTERN, 4'b1101, pattern matched over transmitted bits, first-sent bit is the MSB.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- load  input  1  request to start a frame; sampled only in IDLE.
- data_in  input  WIDTH  frame word, captured when load is accepted.
- out  output  1  serial bit line; this is the detector's in.
- out_valid  output  1  high while out carries a frame bit.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse after the last bit.
- match  output  1  registered pulse, cycle after a bit completes PATTERN.
- match_count  output  $clog2(WIDTH+1)  matches in the current or last frame.

Behaviour:
- Reset, synchronous, high on a clk edge:
  - State goes to IDLE.
  - out, out_valid, busy, done and match go to 0.
  - match_count, shift register, history and bit counter are cleared.
  - Reset overrides every other input. Reset in mid-frame aborts the frame; no done pulse follows.
- State machine:
  - IDLE
    - out=0, out_valid=0, busy=0.
    - load=1 at an edge captures data_in, clears match_count and history, sets bit counter to 0, goes to SHIFT.
  - SHIFT
    - Bit k (k=0..WIDTH-1) equals data_in[WIDTH-1-k].
    - Bit k drives out in cycle k+1 after the accepting edge, with out_valid=1 and busy=1.
    - At each edge the shift register moves left and the counter increments.
    - After bit WIDTH-1 the state goes to DONE.
  - DONE
    - Lasts exactly one cycle: done=1, busy=1, out=0, out_valid=0.
    - Then returns to IDLE.
    - load is ignored in SHIFT and DONE and is not queued.
- Back-to-back frames:
  - load held high in the first IDLE cycle after DONE starts the next frame.
  - Minimum gap is one IDLE cycle between frames (the DONE cycle plus the IDLE cycle).
- Reference matcher:
  - History holds the last PAT_LEN-1 bits sent in the current frame.
  - At each SHIFT edge, the window {history, out} is compared with PATTERN.
  - The compare counts only when the bit counter >= PAT_LEN-1. Matches are never counted across a frame boundary, because history is cleared on load.
  - On equality: match=1 for the next cycle and match_count increments at that edge.
  - Matching overlaps: history is not cleared on a match.
- match timing:
  - match is 0 in IDLE except in the cycle following the last SHIFT edge.
  - A match on the final bit pulses match in the DONE cycle.
- match_count:
  - Saturates at its maximum; this cannot be reached for a legal PAT_LEN.
  - Holds its value in IDLE until the next accepted load.
- Width rules:
  - Bit counter is $clog2(WIDTH) bits.
  - No arithmetic wraps within a frame.

Test Plan:
1. After rst held for 2 edges, then released -> out=0, out_valid=0, busy=0, done=0, match=0, match_count=0 while idle.
2. Load 16'hDB6D (1101101101101101) -> out follows those bits on cycles 1..16 with out_valid=1 -> match pulses after bits 3, 6, 9, 12, 15 (the last one in the DONE cycle) -> done at cycle 17 -> match_count=5.
3. Load 16'h0000, then 16'hFFFF back-to-back (load high throughout) -> second frame starts one cycle after DONE -> 0 matches each -> match_count=0 after each done.
4. Frame 16'h0003 then frame 16'h4000 (the concatenation contains 1101 across the boundary) -> no match pulse -> match_count=0 for both frames.
5. Load 16'hDB6D; pulse load again during bit 5; assert rst at bit 8 -> the mid-frame load has no effect -> after rst: all outputs 0, no done pulse -> a subsequent load 16'h000D completes with match_count=1 and match in the DONE cycle.
6. Randomised 200 frames, with the serializer's out driving the 1101 detector's in -> detector out pulses align with match -> per-frame pulse count equals match_count.
